// File: rtl/cpu_pkg.sv
// Shared CPU definitions: interrupt dispatch states, default vector layout
// and the interrupt source index names.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    PUSH_HI,
    PUSH_LO,
    JUMP
  } int_state_t;

  localparam logic [15:0] VEC_BASE_DEF   = 16'h0040;
  localparam int          VEC_STRIDE_DEF = 8;

  localparam int VBLANK = 0;
  localparam int LCD    = 1;
  localparam int TIMER  = 2;
  localparam int SERIAL = 3;
  localparam int JOYPAD = 4;

endpackage

// File: rtl/int_dispatch_if.sv
// Stack write port between the interrupt dispatcher and memory.
// Handshake: the master raises mem_we with mem_addr/mem_wdata and holds all three
// stable until a cycle where mem_rdy=1; the write transfers on that cycle's edge.
interface int_dispatch_if;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rdy;

  modport master (output mem_we, output mem_addr, output mem_wdata, input mem_rdy);
  modport slave  (input mem_we, input mem_addr, input mem_wdata, output mem_rdy);
endinterface

// File: rtl/int_dispatch_prio_enc.sv
// Lowest-index-first priority encoder over the interrupt request lines.
module prio_enc #(
  parameter int NUM_IRQ = 5,
  parameter int IW      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic [IW-1:0]      idx,
  output logic               valid
);

  // Scan downwards so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/int_dispatch.sv
// Interrupt dispatch unit: owns IME/EI, picks a source at instruction
// boundaries, pushes the return address and jumps to the source's vector.
module int_dispatch
  import cpu_pkg::*;
#(
  parameter int          NUM_IRQ    = 5,
  parameter logic [15:0] VEC_BASE   = VEC_BASE_DEF,
  parameter int          VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic               core_clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic               instr_boundary,
  input  logic               ime_set,
  input  logic               ime_set_dly,
  input  logic               ime_clr,
  input  logic [15:0]        pc_in,
  input  logic [15:0]        sp_in,
  int_dispatch_if.master     mem,
  output logic               ime,
  output logic               busy,
  output logic [NUM_IRQ-1:0] irq_clr,
  output logic               pc_load,
  output logic [15:0]        pc_vec,
  output logic               sp_load,
  output logic [15:0]        sp_new,
  output logic               wake,
  output int_state_t         state_dbg
);

  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  int_state_t    state_q, state_d;
  logic [IW-1:0] idx_q, enc_idx;
  logic          enc_valid;
  logic [15:0]   ret_q, sp0_q;
  logic          ime_q, ei_pend_q;
  logic          dispatch;

  prio_enc #(.NUM_IRQ(NUM_IRQ), .IW(IW)) u_prio_enc (
    .req   (irq_req),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // An EI boundary sees ime_q=0, so it can never start a dispatch itself.
  assign dispatch = (state_q == IDLE) && instr_boundary && ime_q && enc_valid;

  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      ret_q     <= '0;
      sp0_q     <= '0;
      ime_q     <= 1'b0;
      ei_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (dispatch) begin
        idx_q <= enc_idx;
        ret_q <= pc_in;
        sp0_q <= sp_in;
      end
      if (ime_clr)                           ime_q <= 1'b0;
      else if (ime_set)                      ime_q <= 1'b1;
      else if (dispatch)                     ime_q <= 1'b0;
      else if (instr_boundary && ei_pend_q)  ime_q <= 1'b1;
      if (ime_clr)             ei_pend_q <= 1'b0;
      else if (ime_set_dly)    ei_pend_q <= 1'b1;
      else if (instr_boundary) ei_pend_q <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (dispatch) state_d = ACK;
      ACK:     state_d = PUSH_HI;
      PUSH_HI: if (mem.mem_rdy) state_d = PUSH_LO;
      PUSH_LO: if (mem.mem_rdy) state_d = JUMP;
      JUMP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode only registered state, so they are stable for a whole state.
  always_comb begin
    busy          = (state_q != IDLE);
    irq_clr       = '0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    pc_load       = 1'b0;
    pc_vec        = '0;
    sp_load       = 1'b0;
    sp_new        = '0;
    unique case (state_q)
      ACK: irq_clr = NUM_IRQ'(1) << idx_q;
      PUSH_HI: begin
        mem.mem_we    = 1'b1;
        mem.mem_addr  = sp0_q - 16'd1;
        mem.mem_wdata = ret_q[15:8];
      end
      PUSH_LO: begin
        mem.mem_we    = 1'b1;
        mem.mem_addr  = sp0_q - 16'd2;
        mem.mem_wdata = ret_q[7:0];
      end
      JUMP: begin
        pc_load = 1'b1;
        pc_vec  = VEC_BASE + 16'(idx_q) * 16'(VEC_STRIDE);
        sp_load = 1'b1;
        sp_new  = sp0_q - 16'd2;
      end
      default: ;
    endcase
  end

  assign ime       = ime_q;
  assign wake      = |irq_req;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_int_dispatch.sv
// Self-checking bench for int_dispatch: directed literal cases plus random
// traffic compared every cycle against a queue-based behavioural model.
module tb_int_dispatch;
  import cpu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT (default configuration) ----------------
  logic [4:0]  irq_req;
  logic        instr_boundary, ime_set, ime_set_dly, ime_clr;
  logic [15:0] pc_in, sp_in;
  logic        ime, busy, pc_load, sp_load, wake;
  logic [4:0]  irq_clr;
  logic [15:0] pc_vec, sp_new;
  int_state_t  state_dbg;
  int_dispatch_if bus ();

  int_dispatch dut (
    .core_clk(clk), .reset(rst), .irq_req(irq_req), .instr_boundary(instr_boundary),
    .ime_set(ime_set), .ime_set_dly(ime_set_dly), .ime_clr(ime_clr),
    .pc_in(pc_in), .sp_in(sp_in), .mem(bus), .ime(ime), .busy(busy),
    .irq_clr(irq_clr), .pc_load(pc_load), .pc_vec(pc_vec), .sp_load(sp_load),
    .sp_new(sp_new), .wake(wake), .state_dbg(state_dbg)
  );

  // ---------------- DUT (8 sources, custom vectors) ----------------
  logic [7:0]  irq_req8, irq_clr8;
  logic        boundary8, ime_set8, ime8, busy8, pc_load8, sp_load8, wake8;
  logic [15:0] pc_vec8, sp_new8;
  int_state_t  state_dbg8;
  int_dispatch_if bus8 ();

  int_dispatch #(.NUM_IRQ(8), .VEC_BASE(16'h0100), .VEC_STRIDE(16)) dut8 (
    .core_clk(clk), .reset(rst), .irq_req(irq_req8), .instr_boundary(boundary8),
    .ime_set(ime_set8), .ime_set_dly(1'b0), .ime_clr(1'b0),
    .pc_in(16'h4321), .sp_in(16'hD000), .mem(bus8), .ime(ime8), .busy(busy8),
    .irq_clr(irq_clr8), .pc_load(pc_load8), .pc_vec(pc_vec8), .sp_load(sp_load8),
    .sp_new(sp_new8), .wake(wake8), .state_dbg(state_dbg8)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pending work of a dispatch: an acknowledge, a queue of stack writes, a jump.
  logic [23:0] exp_q[$];
  logic        m_ime, m_ei, m_ack, m_jump;
  logic [2:0]  m_idx;
  logic [15:0] m_sp0;
  logic        e_busy, e_we, e_pcl, disp;
  logic [4:0]  e_clr;
  logic [15:0] e_addr, e_vec, e_spn;
  logic [7:0]  e_data;

  initial begin
    m_ime = 0; m_ei = 0; m_ack = 0; m_jump = 0; m_idx = 0; m_sp0 = 0;
  end

  always @(negedge clk) begin
    check("cmp_wake", wake, |irq_req);
    if (rst) begin
      check("rst_ime", ime, 0);       check("rst_busy", busy, 0);
      check("rst_clr", irq_clr, 0);   check("rst_we", bus.mem_we, 0);
      check("rst_addr", bus.mem_addr, 0); check("rst_data", bus.mem_wdata, 0);
      check("rst_pcl", pc_load, 0);   check("rst_vec", pc_vec, 0);
      check("rst_spl", sp_load, 0);   check("rst_spn", sp_new, 0);
      m_ime = 0; m_ei = 0; m_ack = 0; m_jump = 0; exp_q.delete();
    end else begin
      e_busy = m_ack || (exp_q.size() != 0) || m_jump;
      e_clr  = m_ack ? (5'd1 << m_idx) : 5'd0;
      e_we   = !m_ack && (exp_q.size() != 0);
      e_addr = e_we ? exp_q[0][23:8] : 16'h0;
      e_data = e_we ? exp_q[0][7:0] : 8'h0;
      e_pcl  = !m_ack && (exp_q.size() == 0) && m_jump;
      e_vec  = e_pcl ? 16'h0040 + 16'(m_idx) * 16'd8 : 16'h0;
      e_spn  = e_pcl ? m_sp0 - 16'd2 : 16'h0;
      check("cmp_ime", ime, m_ime);     check("cmp_busy", busy, e_busy);
      check("cmp_clr", irq_clr, e_clr); check("cmp_we", bus.mem_we, e_we);
      check("cmp_addr", bus.mem_addr, e_addr); check("cmp_data", bus.mem_wdata, e_data);
      check("cmp_pcl", pc_load, e_pcl); check("cmp_vec", pc_vec, e_vec);
      check("cmp_spl", sp_load, e_pcl); check("cmp_spn", sp_new, e_spn);
      // advance the model to what the coming edge produces
      disp = !e_busy && instr_boundary && m_ime && (irq_req != 0);
      if (m_ack) m_ack = 0;
      else if (exp_q.size() != 0) begin
        if (bus.mem_rdy) void'(exp_q.pop_front());
      end else if (m_jump) m_jump = 0;
      if (ime_clr) m_ime = 0;
      else if (ime_set) m_ime = 1;
      else if (disp) m_ime = 0;
      else if (instr_boundary && m_ei) m_ime = 1;
      if (ime_clr) m_ei = 0;
      else if (ime_set_dly) m_ei = 1;
      else if (instr_boundary) m_ei = 0;
      if (disp) begin
        for (int i = 4; i >= 0; i--) if (irq_req[i]) m_idx = 3'(i);
        m_ack = 1; m_jump = 1; m_sp0 = sp_in;
        exp_q.push_back({sp_in - 16'd1, pc_in[15:8]});
        exp_q.push_back({sp_in - 16'd2, pc_in[7:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_boundary();
    instr_boundary = 1; tick(); instr_boundary = 0;
  endtask

  task automatic pulse_ime_set();
    ime_set = 1; tick(); ime_set = 0;
  endtask

  // Called right after the dispatching edge T; checks cycles T+1..T+4 literally.
  task automatic expect_dispatch(input logic [4:0] clr, input logic [15:0] a_hi,
                                 input logic [7:0] d_hi, input logic [15:0] a_lo,
                                 input logic [7:0] d_lo, input logic [15:0] vec,
                                 input logic [15:0] spn);
    @(negedge clk);
    check("d_ack_clr", irq_clr, clr); check("d_ack_busy", busy, 1);
    @(negedge clk);
    check("d_hi_we", bus.mem_we, 1); check("d_hi_addr", bus.mem_addr, a_hi);
    check("d_hi_data", bus.mem_wdata, d_hi); check("d_hi_clr", irq_clr, 0);
    @(negedge clk);
    check("d_lo_addr", bus.mem_addr, a_lo); check("d_lo_data", bus.mem_wdata, d_lo);
    @(negedge clk);
    check("d_jmp_pcl", pc_load, 1); check("d_jmp_vec", pc_vec, vec);
    check("d_jmp_spn", sp_new, spn); check("d_jmp_ime", ime, 0);
    tick();
  endtask

  // ---------------- stimulus ----------------
  int cnt;

  initial begin
    rst = 1; irq_req = 0; instr_boundary = 0; ime_set = 0; ime_set_dly = 0; ime_clr = 0;
    pc_in = 0; sp_in = 0; bus.mem_rdy = 1;
    irq_req8 = 0; boundary8 = 0; ime_set8 = 0; bus8.mem_rdy = 1;
    repeat (3) tick();
    rst = 0;
    tick();

    // basic dispatch of the timer source
    pulse_ime_set();
    pc_in = 16'h1234; sp_in = 16'hFFFE; irq_req = 5'(1 << TIMER);
    pulse_boundary();
    expect_dispatch(5'b00100, 16'hFFFD, 8'h12, 16'hFFFC, 8'h34, 16'h0050, 16'hFFFC);

    // several requests: lowest index wins, only its bit is cleared
    pulse_ime_set();
    irq_req = 5'b10110; pc_in = 16'h5A00; sp_in = 16'hC000;
    pulse_boundary();
    expect_dispatch(5'b00010, 16'hBFFF, 8'h5A, 16'hBFFE, 8'h00, 16'h0048, 16'hBFFE);

    // EI: the enabling boundary does not dispatch, the next one does
    irq_req = 5'b00001; pc_in = 16'h0200; sp_in = 16'hD000;
    ime_set_dly = 1; tick(); ime_set_dly = 0;
    check("ei_not_yet", ime, 0);
    pulse_boundary();
    @(negedge clk);
    check("ei_no_disp", busy, 0); check("ei_ime_on", ime, 1);
    tick(); tick();
    pulse_boundary();
    expect_dispatch(5'b00001, 16'hCFFF, 8'h02, 16'hCFFE, 8'h00, 16'h0040, 16'hCFFE);

    // memory stall in PUSH_HI for three cycles
    pulse_ime_set();
    irq_req = 5'b00001; pc_in = 16'hBEEF; sp_in = 16'h8000;
    pulse_boundary();
    bus.mem_rdy = 0;
    cnt = 0;
    @(negedge clk); if (busy) cnt++;
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk); if (busy) cnt++;
      check("stall_we", bus.mem_we, 1); check("stall_addr", bus.mem_addr, 16'h7FFF);
      check("stall_data", bus.mem_wdata, 8'hBE);
    end
    tick();
    bus.mem_rdy = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
    end
    check("stall_busy_len", cnt, 4 + 3);
    tick();

    // stack pointer wrap
    pulse_ime_set();
    irq_req = 5'(1 << JOYPAD); pc_in = 16'hABCD; sp_in = 16'h0001;
    pulse_boundary();
    expect_dispatch(5'b10000, 16'h0000, 8'hAB, 16'hFFFF, 8'hCD, 16'h0060, 16'hFFFF);
    irq_req = 0;

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      irq_req        = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      instr_boundary = ($urandom_range(0, 2) == 0);
      ime_set        = ($urandom_range(0, 11) == 0);
      ime_set_dly    = ($urandom_range(0, 11) == 0);
      ime_clr        = ($urandom_range(0, 19) == 0);
      bus.mem_rdy    = ($urandom_range(0, 3) != 0);
      pc_in          = 16'($urandom);
      sp_in          = 16'($urandom);
      tick();
    end
    irq_req = 0; instr_boundary = 0; ime_set = 0; ime_set_dly = 0; ime_clr = 0;
    bus.mem_rdy = 1;
    for (int k = 0; k < 20 && busy; k++) tick();
    check("rand_drained", busy, 0);

    // reset in PUSH_LO aborts the dispatch
    pulse_ime_set();
    irq_req = 5'b00010; pc_in = 16'h7777; sp_in = 16'h9000;
    pulse_boundary();
    ime_set = 1; tick(); ime_set = 0;
    tick();
    check("pre_rst_addr", bus.mem_addr, 16'h8FFE); check("pre_rst_ime", ime, 1);
    rst = 1; #1;
    check("rst_mid_we", bus.mem_we, 0); check("rst_mid_busy", busy, 0);
    check("rst_mid_ime", ime, 0);
    tick(); tick();
    rst = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); check("post_rst_pcl", pc_load, 0);
    end
    tick();
    irq_req = 0;

    // 8-source instance with base 0x0100 and stride 16
    ime_set8 = 1; tick(); ime_set8 = 0;
    irq_req8 = 8'h80;
    boundary8 = 1; tick(); boundary8 = 0;
    @(negedge clk); check("n8_clr", irq_clr8, 8'h80);
    repeat (3) @(negedge clk);
    check("n8_pcl", pc_load8, 1); check("n8_vec", pc_vec8, 16'h0170);
    check("n8_spn", sp_new8, 16'hCFFE);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
